// File: rtl/karatsuba_mul8.sv
// Sequential 8x8 unsigned multiplier using one-level Karatsuba decomposition.
// It time-shares an external combinational 5x5 product ROM over three lookups.
module karatsuba_mul8 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [9:0]  rom_addr,
   input  logic [9:0]  rom_data,
   output logic        busy,
   output logic        done,
   output logic [15:0] product,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_Z0   = 3'd1,
      S_Z2   = 3'd2,
      S_Z1   = 3'd3,
      S_COMB = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_a;
   logic [7:0]  r_b;
   logic [9:0]  r_z0;
   logic [9:0]  r_z1;
   logic [9:0]  r_z2;
   logic [15:0] r_product;
   logic        r_done;

   logic [4:0]  w_sa;
   logic [4:0]  w_sb;
   logic [9:0]  w_mid;
   logic [15:0] w_sum;

   // Handshake: start is sampled only in IDLE; busy is high from the accepting
   // edge until the result edge; done pulses for one cycle as product updates.
   // A start seen while busy is dropped, not queued.

   assign w_sa  = {1'b0, r_a[3:0]} + {1'b0, r_a[7:4]};
   assign w_sb  = {1'b0, r_b[3:0]} + {1'b0, r_b[7:4]};
   // Middle term (al+ah)(bl+bh) - ah*bh - al*bl is never negative.
   assign w_mid = r_z1 - r_z2 - r_z0;
   assign w_sum = ({6'b0, r_z2} << 8) + ({6'b0, w_mid} << 4) + {6'b0, r_z0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_Z0;
         S_Z0:    w_next = S_Z2;
         S_Z2:    w_next = S_Z1;
         S_Z1:    w_next = S_COMB;
         S_COMB:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      rom_addr = 10'd0;
      busy     = 1'b0;
      case (r_state)
         S_Z0:   begin rom_addr = {1'b0, r_b[3:0], 1'b0, r_a[3:0]}; busy = 1'b1; end
         S_Z2:   begin rom_addr = {1'b0, r_b[7:4], 1'b0, r_a[7:4]}; busy = 1'b1; end
         S_Z1:   begin rom_addr = {w_sb, w_sa};                     busy = 1'b1; end
         S_COMB: busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a       <= 8'd0;
         r_b       <= 8'd0;
         r_z0      <= 10'd0;
         r_z1      <= 10'd0;
         r_z2      <= 10'd0;
         r_product <= 16'd0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_a <= a;
               r_b <= b;
            end
            S_Z0:   r_z0 <= rom_data;
            S_Z2:   r_z2 <= rom_data;
            S_Z1:   r_z1 <= rom_data;
            S_COMB: begin
               r_product <= w_sum;
               r_done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign done        = r_done;
   assign product     = r_product;
   assign o_dbg_state = r_state;

endmodule
